// File: rtl/wb_stage.sv
// wb_stage: writeback stage that registers either the ALU result or the extracted load word
// onto the register-file write port. Defining WB_FWD_EN adds the forwarding-compare ports.
module wb_stage #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_RegWrite,
    input  logic        in_MemToReg,
    input  logic [1:0]  in_LoadType,
    input  logic        in_LoadSigned,
    input  logic [1:0]  in_ByteOffset,
    input  logic [4:0]  in_RD_Address,
    input  logic [31:0] in_ALUResult,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    output logic        RegWrite,
    output logic [4:0]  RD_Address,
    output logic [31:0] RDdata,
    output logic        err
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]  RS_Address,
    input  logic [4:0]  RT_Address,
    output logic        fwd_RS_hit,
    output logic        fwd_RT_hit,
    output logic [31:0] fwd_data
`endif
);

    // state    | meaning
    // IDLE     | no instruction in flight, accepting
    // WAIT_MEM | load accepted, waiting for mem_valid or timeout
    // WRITE    | write port driven this cycle, accepting the next instruction
    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    localparam int CW = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic          r_lsigned;
    logic [1:0]    r_ltype;
    logic [1:0]    r_off;
    logic [4:0]    r_rd;
    logic          r_regwrite;
    logic          r_err;
    logic [4:0]    r_rd_addr;
    logic [31:0]   r_rddata;
    logic          w_accept;
    logic          w_tmo;
    logic          w_err;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;

    assign in_ready = rst_n && (r_state != WAIT_MEM);
    assign w_accept = in_valid && in_ready;
    assign w_tmo    = (r_cnt == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        case (r_state)
            IDLE, WRITE: begin
                if (w_accept) begin
                    w_state_nxt = in_MemToReg ? WAIT_MEM : WRITE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_MEM: begin
                // returned data wins over a timeout landing in the same cycle
                if (mem_valid) begin
                    w_state_nxt = WRITE;
                end else if (w_tmo) begin
                    w_state_nxt = IDLE;
                    w_err       = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0: w_byte = mem_data[7:0];
            2'd1: w_byte = mem_data[15:8];
            2'd2: w_byte = mem_data[23:16];
            2'd3: w_byte = mem_data[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_off[1] ? mem_data[31:16] : mem_data[15:0];
        case (r_ltype)
            2'b01:   w_load = {{24{r_lsigned & w_byte[7]}}, w_byte};
            2'b10:   w_load = {{16{r_lsigned & w_half[15]}}, w_half};
            default: w_load = mem_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_lsigned  <= 1'b0;
            r_ltype    <= 2'b00;
            r_off      <= 2'b00;
            r_rd       <= 5'd0;
            r_regwrite <= 1'b0;
            r_err      <= 1'b0;
            r_rd_addr  <= 5'd0;
            r_rddata   <= 32'd0;
        end else begin
            r_regwrite <= 1'b0;
            r_err      <= w_err;
            if (w_accept) begin
                if (in_MemToReg) begin
                    r_we      <= in_RegWrite;
                    r_lsigned <= in_LoadSigned;
                    r_ltype   <= in_LoadType;
                    r_off     <= in_ByteOffset;
                    r_rd      <= in_RD_Address;
                    r_cnt     <= '0;
                end else begin
                    r_rd_addr  <= in_RD_Address;
                    r_rddata   <= in_ALUResult;
                    r_regwrite <= in_RegWrite && (in_RD_Address != 5'd0);
                end
            end else if (r_state == WAIT_MEM) begin
                if (mem_valid) begin
                    r_rd_addr  <= r_rd;
                    r_rddata   <= w_load;
                    r_regwrite <= r_we && (r_rd != 5'd0);
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign RegWrite   = r_regwrite;
    assign RD_Address = r_rd_addr;
    assign RDdata     = r_rddata;
    assign err        = r_err;

`ifdef WB_FWD_EN
    assign fwd_RS_hit = r_regwrite && (RS_Address == r_rd_addr);
    assign fwd_RT_hit = r_regwrite && (RT_Address == r_rd_addr);
    assign fwd_data   = r_rddata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed bench for wb_stage; writes are scored against a queue of expected
// register-file writes, timeout behaviour is checked on a second instance with MEM_TIMEOUT=4.
module tb_wb_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv, iv_t, mv, mv_t;
    logic        rw, m2r, ls;
    logic [1:0]  lt, off;
    logic [4:0]  rd;
    logic [31:0] alu, md;

    logic        rdy, we, err;
    logic [4:0]  rda;
    logic [31:0] rdd;
    logic        rdy_t, we_t, err_t;
    logic [4:0]  rda_t;
    logic [31:0] rdd_t;
`ifdef WB_FWD_EN
    logic [4:0]  rs = 5'd0, rt = 5'd0;
    logic        rs_hit, rt_hit, rs_hit_t, rt_hit_t;
    logic [31:0] fwd, fwd_t;
`endif

    wb_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdy),
        .in_RegWrite(rw), .in_MemToReg(m2r), .in_LoadType(lt), .in_LoadSigned(ls),
        .in_ByteOffset(off), .in_RD_Address(rd), .in_ALUResult(alu),
        .mem_valid(mv), .mem_data(md),
        .RegWrite(we), .RD_Address(rda), .RDdata(rdd), .err(err)
`ifdef WB_FWD_EN
        , .RS_Address(rs), .RT_Address(rt), .fwd_RS_hit(rs_hit), .fwd_RT_hit(rt_hit), .fwd_data(fwd)
`endif
    );

    wb_stage #(.MEM_TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_t), .in_ready(rdy_t),
        .in_RegWrite(rw), .in_MemToReg(m2r), .in_LoadType(lt), .in_LoadSigned(ls),
        .in_ByteOffset(off), .in_RD_Address(rd), .in_ALUResult(alu),
        .mem_valid(mv_t), .mem_data(md),
        .RegWrite(we_t), .RD_Address(rda_t), .RDdata(rdd_t), .err(err_t)
`ifdef WB_FWD_EN
        , .RS_Address(rs), .RT_Address(rt), .fwd_RS_hit(rs_hit_t), .fwd_RT_hit(rt_hit_t), .fwd_data(fwd_t)
`endif
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] t, input logic s,
                                               input logic [1:0] o, input logic [31:0] d);
        logic [31:0] v;
        if (t == 2'b01) begin
            v = (d >> (8 * o)) & 32'h0000_00FF;
            if (s && v[7]) v = v | 32'hFFFF_FF00;
        end else if (t == 2'b10) begin
            v = (d >> (o[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (s && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    // scoreboard: every observed write must match the oldest expected one
    always @(negedge clk) begin
        if (we === 1'b1) begin
            int n;
            wr_t e;
            n = sb.size();
            check("write_expected", (n > 0) ? 32'd1 : 32'd0, 32'd1);
            if (n > 0) begin
                e = sb.pop_front();
                check("write_addr", {27'd0, rda}, {27'd0, e.a});
                check("write_data", rdd, e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic m, input logic w, input logic [1:0] t, input logic s,
                          input logic [1:0] o, input logic [4:0] a, input logic [31:0] r);
        m2r = m; rw = w; lt = t; ls = s; off = o; rd = a; alu = r;
    endtask

    task automatic alu_op(input logic w, input logic [4:0] a, input logic [31:0] r);
        set_op(1'b0, w, 2'b00, 1'b0, 2'b00, a, r);
        iv = 1'b1;
        if (w && a != 5'd0) sb.push_back('{a: a, d: r});
        check("alu_ready", {31'd0, rdy}, 32'd1);
        tick();
        iv = 1'b0;
    endtask

    task automatic load_op(input logic w, input logic [1:0] t, input logic s, input logic [1:0] o,
                           input logic [4:0] a, input logic [31:0] d, input int waits);
        set_op(1'b1, w, t, s, o, a, 32'hDEAD_BEEF);
        iv = 1'b1;
        check("load_ready", {31'd0, rdy}, 32'd1);
        tick();
        iv = 1'b0;
        for (int i = 0; i < waits; i++) begin
            check("wait_ready_low", {31'd0, rdy}, 32'd0);
            tick();
        end
        check("wait_ready_low", {31'd0, rdy}, 32'd0);
        md = d;
        mv = 1'b1;
        if (w && a != 5'd0) sb.push_back('{a: a, d: model_load(t, s, o, d)});
        tick();
        mv = 1'b0;
        check("load_we", {31'd0, we}, {31'd0, (w && a != 5'd0)});
        tick();
        check("sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        iv = 0; iv_t = 0; mv = 0; mv_t = 0;
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd0, 32'd0);
        md = 32'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_rda", {27'd0, rda}, 32'd0);
        check("rst_rdd", rdd, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ready", {31'd0, rdy}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, rdy}, 32'd1);

        // single ALU op: visible for exactly one cycle, then held
        alu_op(1'b1, 5'd5, 32'h0000_1234);
        check("alu_we", {31'd0, we}, 32'd1);
        check("alu_rda", {27'd0, rda}, 32'd5);
        check("alu_rdd", rdd, 32'h0000_1234);
        tick();
        check("alu_we_drop", {31'd0, we}, 32'd0);
        check("hold_rda", {27'd0, rda}, 32'd5);
        check("hold_rdd", rdd, 32'h0000_1234);

        // byte load, 4 wait cycles, signed then unsigned
        load_op(1'b1, 2'b01, 1'b1, 2'd3, 5'd9, 32'h80FF_0000, 4);
        check("sbyte_rdd", rdd, 32'hFFFF_FF80);
        load_op(1'b1, 2'b01, 1'b0, 2'd3, 5'd9, 32'h80FF_0000, 4);
        check("ubyte_rdd", rdd, 32'h0000_0080);

        // mem_valid in IDLE is ignored
        md = 32'h1111_1111;
        mv = 1'b1;
        tick();
        mv = 1'b0;
        check("idle_mv_ignored", {31'd0, we}, 32'd0);

        load_op(1'b1, 2'b10, 1'b1, 2'd2, 5'd17, 32'h8001_1234, 0);
        load_op(1'b1, 2'b10, 1'b0, 2'd1, 5'd18, 32'h0000_F00D, 1);
        check("uhalf_rdd", rdd, 32'h0000_F00D);
        load_op(1'b1, 2'b01, 1'b1, 2'd1, 5'd19, 32'h0000_7F00, 2);
        load_op(1'b1, 2'b11, 1'b1, 2'd2, 5'd20, 32'h8765_4321, 0);
        load_op(1'b0, 2'b00, 1'b0, 2'd0, 5'd21, 32'h0BAD_0BAD, 1);

        // back-to-back ALU ops: r0 suppressed, then r31
        alu_op(1'b1, 5'd0, 32'd3);
        check("r0_no_write", {31'd0, we}, 32'd0);
        check("r0_ready", {31'd0, rdy}, 32'd1);
        alu_op(1'b1, 5'd31, 32'd7);
        check("r31_we", {31'd0, we}, 32'd1);
        check("r31_rda", {27'd0, rda}, 32'd31);
        check("r31_rdd", rdd, 32'd7);
        check("r31_ready", {31'd0, rdy}, 32'd1);
        alu_op(1'b0, 5'd4, 32'h4444);
        check("no_regwrite", {31'd0, we}, 32'd0);
        tick();

        // timeout with MEM_TIMEOUT=4
        set_op(1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 5'd12, 32'd0);
        iv_t = 1'b1;
        check("tmo_accept_ready", {31'd0, rdy_t}, 32'd1);
        tick();
        iv_t = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("tmo_err_low", {31'd0, err_t}, 32'd0);
            check("tmo_ready_low", {31'd0, rdy_t}, 32'd0);
            tick();
        end
        check("tmo_err_pulse", {31'd0, err_t}, 32'd1);
        check("tmo_no_write", {31'd0, we_t}, 32'd0);
        check("tmo_idle_ready", {31'd0, rdy_t}, 32'd1);
        tick();
        check("tmo_err_drop", {31'd0, err_t}, 32'd0);
        check("tmo_no_write2", {31'd0, we_t}, 32'd0);

        // mem_valid on the timeout cycle wins
        set_op(1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 5'd13, 32'd0);
        iv_t = 1'b1;
        tick();
        iv_t = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("race_err_low", {31'd0, err_t}, 32'd0);
            tick();
        end
        md = 32'hCAFE_F00D;
        mv_t = 1'b1;
        tick();
        mv_t = 1'b0;
        check("race_we", {31'd0, we_t}, 32'd1);
        check("race_rda", {27'd0, rda_t}, 32'd13);
        check("race_rdd", rdd_t, 32'hCAFE_F00D);
        check("race_err", {31'd0, err_t}, 32'd0);
        tick();
        check("race_we_drop", {31'd0, we_t}, 32'd0);
        check("race_err_after", {31'd0, err_t}, 32'd0);

        // reset mid-WAIT_MEM abandons the load
        set_op(1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 5'd10, 32'd0);
        iv = 1'b1;
        tick();
        iv = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_we", {31'd0, we}, 32'd0);
        check("midrst_rda", {27'd0, rda}, 32'd0);
        check("midrst_rdd", rdd, 32'd0);
        check("midrst_ready", {31'd0, rdy}, 32'd0);
        md = 32'h5A5A_5A5A;
        mv = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        mv = 1'b0;
        check("postrst_we", {31'd0, we}, 32'd0);
        check("postrst_rda", {27'd0, rda}, 32'd0);
        check("postrst_rdd", rdd, 32'd0);
        check("postrst_err", {31'd0, err}, 32'd0);
        tick();
        check("postrst_we2", {31'd0, we}, 32'd0);

`ifdef WB_FWD_EN
        rs = 5'd8;
        rt = 5'd3;
        alu_op(1'b1, 5'd8, 32'h0000_0055);
        check("fwd_rs_hit", {31'd0, rs_hit}, 32'd1);
        check("fwd_rt_hit", {31'd0, rt_hit}, 32'd0);
        check("fwd_data", fwd, 32'h0000_0055);
        tick();
        check("fwd_rs_drop", {31'd0, rs_hit}, 32'd0);
`endif

        tick();
        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the maximum number of cycles to wait for load data.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: an upstream instruction is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the stage accepts the offer; transfer when in_valid&&in_ready at a rising edge.
REQ-006 SHALL have inputs in_RegWrite (1 bit), in_MemToReg (1 bit), in_LoadType (2 bits: 00 word, 01 byte, 10 half, 11 reserved treated as word), in_LoadSigned (1 bit), in_ByteOffset (2 bits), in_RD_Address (5 bits) and in_ALUResult (32 bits).
REQ-007 SHALL have inputs mem_valid (1 bit) and mem_data (32 bits): returned load word, valid for one cycle.
REQ-008 SHALL have outputs RegWrite (1 bit), RD_Address (5 bits) and RDdata (32 bits), all registered: the register-file write port.
REQ-009 SHALL have output err (1 bit), registered: one-cycle pulse on load timeout.

Function
REQ-010 SHALL use FSM states IDLE, WAIT_MEM and WRITE; in_ready = 1 in IDLE and WRITE, 0 in WAIT_MEM.
REQ-011 SHALL, on acceptance with in_MemToReg=0, load RD_Address/RDdata from in_RD_Address/in_ALUResult, go to WRITE and give 1-cycle latency.
REQ-012 SHALL, on acceptance with in_MemToReg=1, latch the control fields, clear the wait counter and go to WAIT_MEM.
REQ-013 SHALL, in WAIT_MEM with mem_valid=1, register the extracted load data into RDdata and go to WRITE.
REQ-014 SHALL ignore mem_valid in IDLE and WRITE.
REQ-015 SHALL drive RegWrite = latched in_RegWrite AND RD_Address != 0 only during the WRITE cycle, and 0 otherwise; writes to register 0 are suppressed.
REQ-016 SHALL treat an acceptance during WRITE exactly as in IDLE (back-to-back ALU ops, one write per cycle); with no acceptance, WRITE returns to IDLE.
REQ-017 SHALL, for load extraction: word passes mem_data; byte selects bits [8*off+7:8*off]; half selects [15:0] if off[1]=0, else [31:16]; off[0] is ignored for half.
REQ-018 SHALL sign-extend byte/half results to 32 bits when in_LoadSigned=1 and zero-extend them otherwise.
REQ-019 SHALL increment the 8-bit+ wait counter in each WAIT_MEM cycle without mem_valid; on reaching MEM_TIMEOUT it SHALL pulse err for one cycle, perform no write and go to IDLE.
REQ-020 SHALL give mem_valid priority when mem_valid and timeout occur in the same cycle: the write occurs and err stays 0.
REQ-021 SHALL hold RD_Address and RDdata at their last values when not writing.

Reset
REQ-022 SHALL, while rst_n=0 and independent of clk: state=IDLE, RegWrite=0, RD_Address=0, RDdata=0, err=0, counter=0, in_ready=0.
REQ-023 SHALL, on rst_n assertion mid-WAIT_MEM or mid-WRITE, abandon the pending write; no RegWrite pulse follows reset release.

Configuration
REQ-024 SHALL, when macro WB_FWD_EN is defined, add inputs RS_Address and RT_Address (5 bits each) and outputs fwd_RS_hit, fwd_RT_hit (1 bit each, combinational) and fwd_data (32 bits, = RDdata).
REQ-025 SHALL, when WB_FWD_EN is defined, assert fwd_RS_hit = RegWrite && RS_Address == RD_Address, and likewise fwd_RT_hit.
REQ-026 SHALL, without WB_FWD_EN, omit these forwarding ports entirely and leave all other behaviour unchanged.

Verification
REQ-027 SHALL be verified by: ALU op, RD=5, result 0x0000_1234, accepted at edge N -> RegWrite=1, RD_Address=5, RDdata=0x1234 for the cycle after N only.
REQ-028 SHALL be verified by: signed-byte load, off=3, mem_data=0x80FF_0000 after 4 wait cycles -> in_ready=0 while waiting, then RDdata=0xFFFF_FF80 and RegWrite for 1 cycle; a repeat with unsigned byte -> 0x0000_0080.
REQ-029 SHALL be verified by: ALU ops to RD=0 then RD=31 (result 7) back-to-back -> no write for RD=0; a write of 7 to register 31 in the next cycle; in_ready stays 1 throughout.
REQ-030 SHALL be verified by: a load with mem_valid never asserted and MEM_TIMEOUT=4 -> err pulses once after 4 wait cycles, no RegWrite, return to IDLE; a variant with mem_valid on the timeout cycle -> write occurs and err=0.
REQ-031 SHALL be verified by: rst_n driven low mid-WAIT_MEM, then mem_valid -> no write and all outputs 0; with WB_FWD_EN, a write to register 8 with RS_Address=8 -> fwd_RS_hit=1 in the same cycle.
